relay_select_sequencer: RTL and testbench

//  Debounced binary-to-one-hot antenna relay driver with break-before-make sequencing.

---
 rtl/relay_select_sequencer.sv | 161 ++++++++++++++++
 tb/tb_relay_select_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/relay_select_sequencer.sv
// Antenna relay driver: debounces a binary select code and drives one relay at a time.
// Relay changes are break-before-make, with dead time, settle time and TX-inhibit gating.
module relay_select_sequencer #(
  parameter int N_OUT        = 6,
  parameter int SEL_W        = 3,
  parameter int STABLE_CYC   = 16,
  parameter int DEADTIME_CYC = 1000,
  parameter int SETTLE_CYC   = 2000
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic [SEL_W-1:0] I_sel,
  input  logic             I_inhibit,
  output logic [N_OUT-1:0] O_bin,
  output logic             O_ready,
  output logic             O_invalid,
  output logic [SEL_W-1:0] O_cur
);

  localparam int CNT_W = $clog2(STABLE_CYC + 1);
  localparam int TMAX  = (DEADTIME_CYC > SETTLE_CYC) ? DEADTIME_CYC : SETTLE_CYC;
  localparam int TMR_W = $clog2(TMAX + 1);
  localparam logic [SEL_W-1:0] N_CODE = SEL_W'(N_OUT);

  generate
    if ((2 ** SEL_W) < (N_OUT + 1)) begin : g_bad_sel_w
      $error("SEL_W too narrow to encode N_OUT relays plus code 0");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_BREAK, S_MAKE} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   cand_q, cand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   sel_db_q, sel_db_d;
  logic               inv_q, inv_d;
  logic [SEL_W-1:0]   cur_q, cur_d;
  logic [SEL_W-1:0]   nxt_q, nxt_d;
  logic [N_OUT-1:0]   bin_q, bin_d;
  logic               ready_q, ready_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [SEL_W-1:0]   tgt;

  function automatic logic [N_OUT-1:0] onehot(input logic [SEL_W-1:0] k);
    logic [N_OUT-1:0] r;
    r = '0;
    for (int i = 0; i < N_OUT; i++)
      if (k == SEL_W'(i + 1)) r[i] = 1'b1;
    return r;
  endfunction

  assign tgt = (sel_db_q != '0 && sel_db_q <= N_CODE) ? sel_db_q : '0;

  // Debounce: accept the candidate on the edge its run length reaches STABLE_CYC
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    sel_db_d = sel_db_q;
    inv_d    = inv_q;
    if (I_sel != cand_q) begin
      cand_d = I_sel;
      cnt_d  = CNT_W'(1);
      if (STABLE_CYC == 1) begin
        sel_db_d = I_sel;
        inv_d    = (I_sel > N_CODE);
      end
    end else if (cnt_q != CNT_W'(STABLE_CYC)) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(STABLE_CYC - 1)) begin
        sel_db_d = cand_q;
        inv_d    = (cand_q > N_CODE);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    bin_d   = bin_q;
    ready_d = ready_q;
    tmr_d   = tmr_q;
    case (state_q)
      S_IDLE: begin
        if (tgt != cur_q && !I_inhibit) begin
          nxt_d   = tgt;
          ready_d = 1'b0;
          tmr_d   = '0;
          if (cur_q != '0) begin
            state_d = S_BREAK;
            bin_d   = '0;
          end else begin
            // Nothing to release: the new code is applied as the make starts
            state_d = S_MAKE;
            cur_d   = tgt;
            bin_d   = onehot(tgt);
          end
        end
      end
      S_BREAK: begin
        if (tmr_q == TMR_W'(DEADTIME_CYC - 1)) begin
          state_d = S_MAKE;
          cur_d   = nxt_q;
          bin_d   = onehot(nxt_q);
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_MAKE: begin
        if (tmr_q == TMR_W'(SETTLE_CYC - 1)) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        bin_d   = '0;
        cur_d   = '0;
        ready_d = 1'b1;
        tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q  <= S_IDLE;
      cand_q   <= '0;
      cnt_q    <= '0;
      sel_db_q <= '0;
      inv_q    <= 1'b0;
      cur_q    <= '0;
      nxt_q    <= '0;
      bin_q    <= '0;
      ready_q  <= 1'b1;
      tmr_q    <= '0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      sel_db_q <= sel_db_d;
      inv_q    <= inv_d;
      cur_q    <= cur_d;
      nxt_q    <= nxt_d;
      bin_q    <= bin_d;
      ready_q  <= ready_d;
      tmr_q    <= tmr_d;
    end
  end

  assign O_bin     = bin_q;
  assign O_ready   = ready_q;
  assign O_invalid = inv_q;
  assign O_cur     = cur_q;

endmodule

// File: tb/tb_relay_select_sequencer.sv
// Bench for relay_select_sequencer: directed scenarios plus random select/inhibit traffic,
// compared every cycle against an event/deadline model of the relay sequencing rules.
module tb_relay_select_sequencer;
  localparam int N  = 6;
  localparam int SW = 3;
  localparam int ST = 4;
  localparam int DT = 3;
  localparam int SE = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] sel;
  logic          inh;
  logic [N-1:0]  o_bin;
  logic          o_ready, o_invalid;
  logic [SW-1:0] o_cur;

  relay_select_sequencer #(
    .N_OUT(N), .SEL_W(SW), .STABLE_CYC(ST), .DEADTIME_CYC(DT), .SETTLE_CYC(SE)
  ) dut (
    .I_clk(clk), .I_rst(rst), .I_sel(sel), .I_inhibit(inh),
    .O_bin(o_bin), .O_ready(o_ready), .O_invalid(o_invalid), .O_cur(o_cur)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: run length of the input, phase with absolute deadline cycles
  int run_val, run_len, m_db, m_inv;
  int m_cur, m_nxt, m_bin, m_ready, m_phase, m_end, cyc;

  function automatic int oh(input int k);
    return (k >= 1 && k <= N) ? (1 << (k - 1)) : 0;
  endfunction

  task automatic model_reset();
    run_val = 0; run_len = 0; m_db = 0; m_inv = 0;
    m_cur = 0; m_nxt = 0; m_bin = 0; m_ready = 1; m_phase = 0; m_end = 0;
  endtask

  task automatic model_edge(input int s, input int ih);
    int tgt;
    tgt = (m_db >= 1 && m_db <= N) ? m_db : 0;
    if (m_phase == 0) begin
      if (tgt != m_cur && ih == 0) begin
        m_nxt = tgt; m_ready = 0;
        if (m_cur != 0) begin
          m_phase = 1; m_bin = 0; m_end = cyc + DT;
        end else begin
          m_phase = 2; m_cur = tgt; m_bin = oh(tgt); m_end = cyc + SE;
        end
      end
    end else if (m_phase == 1) begin
      if (cyc == m_end) begin
        m_phase = 2; m_cur = m_nxt; m_bin = oh(m_nxt); m_end = cyc + SE;
      end
    end else if (cyc == m_end) begin
      m_phase = 0; m_ready = 1;
    end
    if (s != run_val) begin
      run_val = s; run_len = 1;
    end else if (run_len <= ST) begin
      run_len++;
    end
    if (run_len == ST) begin
      m_db = run_val; m_inv = (run_val > N) ? 1 : 0;
    end
    cyc++;
  endtask

  task automatic check_outputs();
    chk("bin",     32'(o_bin),     32'(m_bin));
    chk("ready",   32'(o_ready),   32'(m_ready));
    chk("invalid", 32'(o_invalid), 32'(m_inv));
    chk("cur",     32'(o_cur),     32'(m_cur));
    chk("onehot",  32'($countones(o_bin) <= 1), 32'd1);
  endtask

  // Called at a negedge; returns at the next negedge
  task automatic step(input int s, input int ih);
    sel = SW'(s);
    inh = ih[0];
    @(posedge clk);
    model_edge(s, ih);
    #1 check_outputs();
    @(negedge clk);
  endtask

  task automatic hold(input int s, input int ih, input int n);
    for (int i = 0; i < n; i++) step(s, ih);
  endtask

  // Asynchronous reset asserted mid-low-phase, released on the following negedge
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sel = '0; inh = 1'b0; cyc = 0;
    model_reset();
    @(negedge clk);
    chk("rst_bin",   32'(o_bin),   32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_cur",   32'(o_cur),   32'd0);
    chk("rst_inv",   32'(o_invalid), 32'd0);
    rst = 1'b0;

    hold(2, 0, 4);
    chk("s1_no_make_yet", 32'(o_bin), 32'd0);
    hold(2, 0, 1);
    chk("s1_make", 32'(o_bin), 32'b000010);
    hold(2, 0, 10);
    hold(5, 0, 16);
    chk("s2_final", 32'(o_bin), 32'b010000);
    hold(4, 0, 3);
    hold(5, 0, 10);
    chk("s3_glitch", 32'(o_cur), 32'd5);
    hold(6, 1, 20);
    chk("s4_inhibited", 32'(o_cur), 32'd5);
    hold(6, 0, 15);
    chk("s4_final", 32'(o_bin), 32'b100000);
    hold(7, 0, 20);
    chk("s5_invalid", 32'(o_invalid), 32'd1);
    chk("s5_cur", 32'(o_cur), 32'd0);
    hold(3, 0, 6);
    do_reset();
    hold(3, 0, 20);
    chk("s6_final", 32'(o_bin), 32'b000100);

    for (int seg = 0; seg < 300; seg++) begin
      int s, ln, ih;
      s  = $urandom_range(0, 7);
      ln = $urandom_range(1, 12);
      ih = ($urandom_range(0, 4) == 0) ? 1 : 0;
      if ($urandom_range(0, 39) == 0) do_reset();
      hold(s, ih, ln);
    end
    hold(0, 0, 25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
